uart_tx_engine: RTL and testbench

//  Parametrised UART transmitter: a FIFO-buffered, self-timed successor to the single-byte tx block.

---
 rtl/uart_tx_engine_pkg.sv | 49 ++++
 rtl/uart_tx_engine_if.sv | 9 +
 rtl/uart_tx_engine_fifo.sv | 56 +++++
 rtl/uart_tx_engine.sv | 184 ++++++++++++++++++
 tb/tb_uart_tx_engine.sv | 391 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_engine_pkg.sv
// Shared definitions for the UART transmit engine: parity encodings,
// FSM state encoding and helpers that decode the data_bits setting.
package uart_tx_engine_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } txState_e;

  // Index of the last data bit sent: 00..11 selects 5..8 bits.
  function automatic logic [2:0] lastBitIdx(input logic [1:0] dataBits);
    return 3'd4 + {1'b0, dataBits};
  endfunction

  // Mask of the data bits that take part in a frame.
  function automatic logic [7:0] dataMask(input logic [1:0] dataBits);
    logic [7:0] mask;
    case (dataBits)
      2'b00:   mask = 8'h1F;
      2'b01:   mask = 8'h3F;
      2'b10:   mask = 8'h7F;
      default: mask = 8'hFF;
    endcase
    return mask;
  endfunction

  // Only the odd and even codes insert a parity bit; 11 behaves as none.
  function automatic logic parityEnabled(input logic [1:0] par);
    return (par == PAR_ODD) || (par == PAR_EVEN);
  endfunction

  // Parity bit that makes the 1-count of data+parity odd or even.
  function automatic logic parityBit(input logic [7:0] data,
                                     input logic [1:0] dataBits,
                                     input logic [1:0] par);
    logic ones;
    ones = ^(data & dataMask(dataBits));
    return (par == PAR_ODD) ? ~ones : ones;
  endfunction

endpackage

// File: rtl/uart_tx_engine_if.sv
// Byte push port of the UART transmit engine (valid/ready handshake).
interface uart_tx_engine_if;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;

  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/uart_tx_engine_fifo.sv
// Synchronous byte FIFO feeding the transmitter. Full/empty come from a
// registered occupancy count, so a push while full is refused even when
// a pop happens in the same cycle.
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         pushData_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         popData_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, rdPtr_q;
  logic [CW-1:0]    count_q;
  logic             doPush, doPop;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign doPush    = push_i && !full_o;
  assign doPop     = pop_i && !empty_o;
  assign popData_o = mem_q[rdPtr_q];
  assign count_o   = count_q;

  // Storage array; written on an accepted push, no reset needed.
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= pushData_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + AW'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + AW'(1);
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// FIFO-buffered, self-timed UART transmitter. Frame: start bit, 5..8 data
// bits LSB first, optional parity, 1 or 2 stop bits. Frame settings are
// captured when a byte is popped, so mid-frame changes only affect the
// next frame. Also handles line break and a graceful tx_en stop.
module uart_tx_engine
  import uart_tx_engine_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DIV_W = 16
) (
  input  logic                   clk,
  input  logic                   rstN,
  uart_tx_engine_if.slave        wr,
  input  logic                   tx_en,
  input  logic                   tx_break,
  input  logic [DIV_W-1:0]       baud_div,
  input  logic [1:0]             data_bits,
  input  logic [1:0]             parity,
  input  logic                   stop2,
  output logic                   uart_tx,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);

  txState_e         state_q;
  logic [DIV_W-1:0] baudCnt_q, baudCnt_d, div_q;
  logic [7:0]       shift_q;
  logic [2:0]       bitIdx_q, lastIdx_q;
  logic             parEn_q, parBit_q, stop2_q, stopSecond_q;
  logic             uart_tx_q, busy_q;

  logic [7:0]       fifoData;
  logic             fifoFull, fifoEmpty;
  logic             bitDone, lastStop, canStart, pop;

  uart_tx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk        (clk),
    .rstN       (rstN),
    .push_i     (wr.wr_valid),
    .pushData_i (wr.wr_data),
    .pop_i      (pop),
    .popData_o  (fifoData),
    .count_o    (fifo_count),
    .full_o     (fifoFull),
    .empty_o    (fifoEmpty)
  );

  assign wr.wr_ready = !fifoFull;
  assign uart_tx     = uart_tx_q;
  assign busy        = busy_q;

  // Bit-time bookkeeping: the counter restarts at every bit boundary.
  always_comb begin
    bitDone   = (baudCnt_q == div_q);
    baudCnt_d = bitDone ? '0 : baudCnt_q + DIV_W'(1);
    lastStop  = !stop2_q || stopSecond_q;
    canStart  = tx_en && !tx_break && !fifoEmpty;
  end

  // A new frame starts from IDLE, or directly out of the final stop-bit
  // cycle so back-to-back frames have no idle gap between them.
  always_comb begin
    pop = 1'b0;
    if (state_q == ST_IDLE && canStart) pop = 1'b1;
    if (state_q == ST_STOP && bitDone && lastStop && canStart) pop = 1'b1;
  end

  // Transmit FSM with registered line and busy outputs.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q      <= ST_IDLE;
      baudCnt_q    <= '0;
      div_q        <= '0;
      shift_q      <= '0;
      bitIdx_q     <= '0;
      lastIdx_q    <= 3'd7;
      parEn_q      <= 1'b0;
      parBit_q     <= 1'b0;
      stop2_q      <= 1'b0;
      stopSecond_q <= 1'b0;
      uart_tx_q    <= 1'b1;
      busy_q       <= 1'b0;
    end else if (pop) begin
      state_q      <= ST_START;
      baudCnt_q    <= '0;
      div_q        <= baud_div;
      shift_q      <= fifoData;
      bitIdx_q     <= '0;
      lastIdx_q    <= lastBitIdx(data_bits);
      parEn_q      <= parityEnabled(parity);
      parBit_q     <= parityBit(fifoData, data_bits, parity);
      stop2_q      <= stop2;
      stopSecond_q <= 1'b0;
      uart_tx_q    <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          baudCnt_q <= '0;
          if (tx_break) begin
            state_q   <= ST_BREAK;
            div_q     <= baud_div;
            stop2_q   <= stop2;
            uart_tx_q <= 1'b0;
          end
        end
        ST_START: begin
          baudCnt_q <= baudCnt_d;
          if (bitDone) begin
            state_q   <= ST_DATA;
            uart_tx_q <= shift_q[0];
            shift_q   <= shift_q >> 1;
            bitIdx_q  <= '0;
          end
        end
        ST_DATA: begin
          baudCnt_q <= baudCnt_d;
          if (bitDone) begin
            if (bitIdx_q == lastIdx_q) begin
              if (parEn_q) begin
                state_q   <= ST_PARITY;
                uart_tx_q <= parBit_q;
              end else begin
                state_q      <= ST_STOP;
                uart_tx_q    <= 1'b1;
                stopSecond_q <= 1'b0;
              end
            end else begin
              uart_tx_q <= shift_q[0];
              shift_q   <= shift_q >> 1;
              bitIdx_q  <= bitIdx_q + 3'd1;
            end
          end
        end
        ST_PARITY: begin
          baudCnt_q <= baudCnt_d;
          if (bitDone) begin
            state_q      <= ST_STOP;
            uart_tx_q    <= 1'b1;
            stopSecond_q <= 1'b0;
          end
        end
        ST_STOP: begin
          baudCnt_q <= baudCnt_d;
          if (bitDone) begin
            if (!lastStop) begin
              stopSecond_q <= 1'b1;
            end else if (tx_break) begin
              state_q   <= ST_BREAK;
              div_q     <= baud_div;
              stop2_q   <= stop2;
              uart_tx_q <= 1'b0;
              busy_q    <= 1'b0;
            end else begin
              state_q   <= ST_IDLE;
              uart_tx_q <= 1'b1;
              busy_q    <= 1'b0;
            end
          end
        end
        ST_BREAK: begin
          baudCnt_q <= '0;
          uart_tx_q <= 1'b0;
          busy_q    <= 1'b0;
          if (!tx_break) begin
            state_q      <= ST_STOP;
            uart_tx_q    <= 1'b1;
            busy_q       <= 1'b1;
            stopSecond_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          uart_tx_q <= 1'b1;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: each task sets up one scenario,
// records the serial line once per clock and compares it with a
// hand-built expected waveform.
module tb_uart_tx_engine;

  localparam int DEPTH = 8;
  localparam int DIV_W = 16;

  logic              clk = 1'b0;
  logic              rstN;
  logic              tx_en, tx_break, stop2;
  logic [DIV_W-1:0]  baud_div;
  logic [1:0]        data_bits, parity;
  logic              uart_tx, busy;
  logic [3:0]        fifo_count;

  uart_tx_engine_if ifc ();

  uart_tx_engine #(.DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .clk        (clk),
    .rstN       (rstN),
    .wr         (ifc),
    .tx_en      (tx_en),
    .tx_break   (tx_break),
    .baud_div   (baud_div),
    .data_bits  (data_bits),
    .parity     (parity),
    .stop2      (stop2),
    .uart_tx    (uart_tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [1023:0] gotLine, expLine;
  int            gotLen, expLen, busyCnt;

  // Watchdog so the run always ends even if the design locks up.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic startScenario();
    gotLine = '0;
    expLine = '0;
    gotLen  = 0;
    expLen  = 0;
    busyCnt = 0;
  endtask

  task automatic expAddLevel(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      expLine[expLen] = v;
      expLen++;
    end
  endtask

  // Expected frame: start, data LSB first, optional parity, stop bit(s).
  task automatic expAddFrame(input logic [7:0] d, input int nb, input int par,
                             input int stops, input int cpb);
    int ones;
    logic pb;
    ones = 0;
    expAddLevel(1'b0, cpb);
    for (int b = 0; b < nb; b++) begin
      expAddLevel(d[b], cpb);
      if (d[b]) ones++;
    end
    if (par == 1 || par == 2) begin
      if (par == 1) pb = ((ones % 2) == 0);
      else          pb = ((ones % 2) == 1);
      expAddLevel(pb, cpb);
    end
    expAddLevel(1'b1, stops * cpb);
  endtask

  task automatic captureLine(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      gotLine[gotLen] = uart_tx;
      gotLen++;
      if (busy) busyCnt++;
    end
  endtask

  function automatic int firstDiff();
    for (int i = 0; i < 1024; i++)
      if (gotLine[i] !== expLine[i]) return i;
    return -1;
  endfunction

  task automatic pushByte(input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      if (ifc.wr_ready) begin
        ifc.wr_valid = 1'b1;
        ifc.wr_data  = d;
        @(negedge clk);
        ifc.wr_valid = 1'b0;
        ok = 1'b1;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL push_timeout: wr_ready stayed low, got accepted=0 need 1");
    end
  endtask

  task automatic setConfig(input logic [DIV_W-1:0] div, input logic [1:0] db,
                           input logic [1:0] par, input logic s2);
    baud_div  = div;
    data_bits = db;
    parity    = par;
    stop2     = s2;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    ifc.wr_valid = 1'b0;
    ifc.wr_data  = 8'h00;
    tx_en    = 1'b1;
    tx_break = 1'b0;
    setConfig(16'd3, 2'b11, 2'b00, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (uart_tx !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_line: got tx=%b busy=%b need tx=1 busy=0", uart_tx, busy);
    end
    rstN = 1'b1;
    @(negedge clk);
    checks++;
    if (fifo_count !== 4'd0) begin
      errors++;
      $display("[TB] FAIL reset_count: got %0d need 0", fifo_count);
    end
    checks++;
    if (ifc.wr_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_ready: got %b need 1", ifc.wr_ready);
    end
    checks++;
    if (uart_tx !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_idle: got %b need 1", uart_tx);
    end
  endtask

  task automatic test_8n1();
    startScenario();
    setConfig(16'd3, 2'b11, 2'b00, 1'b0);
    pushByte(8'h55);
    checks++;
    if (uart_tx !== 1'b1 || fifo_count !== 4'd1) begin
      errors++;
      $display("[TB] FAIL t1_latency: got tx=%b count=%0d need tx=1 count=1", uart_tx, fifo_count);
    end
    captureLine(44);
    expAddFrame(8'h55, 8, 0, 1, 4);
    expAddLevel(1'b1, 4);
    checks++;
    if (gotLine !== expLine) begin
      errors++;
      $display("[TB] FAIL t1_frame: first diff at sample %0d got %b need %b",
               firstDiff(), gotLine[firstDiff()], expLine[firstDiff()]);
    end
    checks++;
    if (busyCnt != 40) begin
      errors++;
      $display("[TB] FAIL t1_busy: got %0d busy cycles need 40", busyCnt);
    end
  endtask

  task automatic test_parity();
    // 7 data bits, 0x03 has two ones: odd parity -> 1, even parity -> 0.
    for (int p = 1; p <= 2; p++) begin
      startScenario();
      setConfig(16'd1, 2'b10, p[1:0], 1'b0);
      pushByte(8'h03);
      captureLine(22);
      expAddFrame(8'h03, 7, p, 1, 2);
      expAddLevel(1'b1, 2);
      checks++;
      if (gotLine !== expLine) begin
        errors++;
        $display("[TB] FAIL t2_frame_par%0d: first diff at sample %0d got %b need %b",
                 p, firstDiff(), gotLine[firstDiff()], expLine[firstDiff()]);
      end
      checks++;
      if (gotLine[16] !== ((p == 1) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("[TB] FAIL t2_parity_bit%0d: got %b need %b", p, gotLine[16], (p == 1));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [9];
    startScenario();
    setConfig(16'd0, 2'b11, 2'b00, 1'b0);
    tx_en = 1'b0;
    for (int i = 0; i < 9; i++) bytes[i] = 8'h30 + 8'(i * 17);
    for (int i = 0; i < DEPTH; i++) pushByte(bytes[i]);
    checks++;
    if (fifo_count !== 4'd8 || ifc.wr_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL t3_full: got count=%0d ready=%b need count=8 ready=0",
               fifo_count, ifc.wr_ready);
    end
    // Push attempted while full in the same cycle as the first pop.
    tx_en = 1'b1;
    ifc.wr_valid = 1'b1;
    ifc.wr_data  = 8'hEE;
    fork
      captureLine(92);
      begin
        @(negedge clk);
        checks++;
        if (fifo_count !== 4'd7) begin
          errors++;
          $display("[TB] FAIL t3_refused: got count=%0d need 7", fifo_count);
        end
        ifc.wr_data = bytes[8];
        @(negedge clk);
        ifc.wr_valid = 1'b0;
        checks++;
        if (fifo_count !== 4'd8) begin
          errors++;
          $display("[TB] FAIL t3_push9: got count=%0d need 8", fifo_count);
        end
      end
    join
    for (int i = 0; i < 9; i++) expAddFrame(bytes[i], 8, 0, 1, 1);
    expAddLevel(1'b1, 2);
    checks++;
    if (gotLine !== expLine) begin
      errors++;
      $display("[TB] FAIL t3_stream: first diff at sample %0d got %b need %b",
               firstDiff(), gotLine[firstDiff()], expLine[firstDiff()]);
    end
    checks++;
    if (busyCnt != 90) begin
      errors++;
      $display("[TB] FAIL t3_busy: got %0d busy cycles need 90", busyCnt);
    end
  endtask

  task automatic test_5bit_2stop();
    startScenario();
    setConfig(16'd0, 2'b00, 2'b00, 1'b1);
    pushByte(8'hE5);
    captureLine(10);
    // 0xE5 low five bits 00101 -> 0,1,0,1,0,0,1,1 then idle.
    expAddFrame(8'h05, 5, 0, 2, 1);
    expAddLevel(1'b1, 2);
    checks++;
    if (gotLine !== expLine) begin
      errors++;
      $display("[TB] FAIL t4_frame: first diff at sample %0d got %b need %b",
               firstDiff(), gotLine[firstDiff()], expLine[firstDiff()]);
    end
    checks++;
    if (busyCnt != 8) begin
      errors++;
      $display("[TB] FAIL t4_busy: got %0d busy cycles need 8", busyCnt);
    end
  endtask

  task automatic test_break();
    startScenario();
    setConfig(16'd1, 2'b11, 2'b00, 1'b0);
    pushByte(8'hA5);
    captureLine(5);
    tx_break = 1'b1;
    ifc.wr_valid = 1'b1;
    ifc.wr_data  = 8'h0F;
    captureLine(1);
    ifc.wr_valid = 1'b0;
    captureLine(24);
    checks++;
    if (fifo_count !== 4'd1) begin
      errors++;
      $display("[TB] FAIL t5_no_pop: got count=%0d need 1", fifo_count);
    end
    tx_break = 1'b0;
    captureLine(24);
    expAddFrame(8'hA5, 8, 0, 1, 2);
    expAddLevel(1'b0, 10);
    expAddLevel(1'b1, 2);
    expAddFrame(8'h0F, 8, 0, 1, 2);
    expAddLevel(1'b1, 2);
    checks++;
    if (gotLine !== expLine) begin
      errors++;
      $display("[TB] FAIL t5_line: first diff at sample %0d got %b need %b",
               firstDiff(), gotLine[firstDiff()], expLine[firstDiff()]);
    end
    checks++;
    if (fifo_count !== 4'd0) begin
      errors++;
      $display("[TB] FAIL t5_drained: got count=%0d need 0", fifo_count);
    end
  endtask

  task automatic test_reset_mid_frame();
    startScenario();
    setConfig(16'd3, 2'b11, 2'b00, 1'b0);
    tx_en = 1'b0;
    pushByte(8'h00);
    pushByte(8'h81);
    tx_en = 1'b1;
    captureLine(12);
    checks++;
    if (fifo_count !== 4'd1 || uart_tx !== 1'b0) begin
      errors++;
      $display("[TB] FAIL t6_pre: got count=%0d tx=%b need count=1 tx=0", fifo_count, uart_tx);
    end
    #2 rstN = 1'b0;
    #1;
    checks++;
    if (uart_tx !== 1'b1 || fifo_count !== 4'd0 || busy !== 1'b0 || ifc.wr_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL t6_async: got tx=%b count=%0d busy=%b ready=%b need 1 0 0 1",
               uart_tx, fifo_count, busy, ifc.wr_ready);
    end
    @(negedge clk);
    rstN = 1'b1;
    startScenario();
    pushByte(8'h3C);
    captureLine(44);
    expAddFrame(8'h3C, 8, 0, 1, 4);
    expAddLevel(1'b1, 4);
    checks++;
    if (gotLine !== expLine) begin
      errors++;
      $display("[TB] FAIL t6_clean: first diff at sample %0d got %b need %b",
               firstDiff(), gotLine[firstDiff()], expLine[firstDiff()]);
    end
  endtask

  task automatic test_baud_change();
    startScenario();
    setConfig(16'd1, 2'b11, 2'b00, 1'b0);
    tx_en = 1'b0;
    pushByte(8'h96);
    pushByte(8'h3A);
    tx_en = 1'b1;
    captureLine(6);
    baud_div = 16'd2;
    captureLine(46);
    expAddFrame(8'h96, 8, 0, 1, 2);
    expAddFrame(8'h3A, 8, 0, 1, 3);
    expAddLevel(1'b1, 2);
    checks++;
    if (gotLine !== expLine) begin
      errors++;
      $display("[TB] FAIL t7_timing: first diff at sample %0d got %b need %b",
               firstDiff(), gotLine[firstDiff()], expLine[firstDiff()]);
    end
    checks++;
    if (busyCnt != 50) begin
      errors++;
      $display("[TB] FAIL t7_busy: got %0d busy cycles need 50", busyCnt);
    end
  endtask

  // Scenarios run in sequence, then a single summary line.
  initial begin
    $display("[TB] uart_tx_engine directed tests starting");
    test_reset();
    test_8n1();
    test_parity();
    test_back_to_back();
    test_5bit_2stop();
    test_break();
    test_reset_mid_frame();
    test_baud_change();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
